mod_148_txop_table_ctrl: RTL

//  Synthesizable owner of the dynamic-PLCA TXOP claim table: one FREE/SOFT/HARD state per node ID.

---
 rtl/mod_148_txop_pkg.sv | 31 +++
 rtl/mod_148_txop_table_ram.sv | 36 +++
 rtl/mod_148_txop_table_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_148_txop_pkg.sv
// Shared definitions for the dynamic-PLCA TXOP claim table.
// Entry states, command opcodes and controller FSM states.
package mod_148_txop_pkg;

  typedef logic [1:0] entry_t;

  localparam entry_t ENT_FREE = 2'b00;
  localparam entry_t ENT_SOFT = 2'b01;
  localparam entry_t ENT_HARD = 2'b10;

  localparam logic [2:0] OP_CLEAR_TABLE = 3'd0;
  localparam logic [2:0] OP_CLEAR_SOFT  = 3'd1;
  localparam logic [2:0] OP_SET_SOFT    = 3'd2;
  localparam logic [2:0] OP_SET_HARD    = 3'd3;
  localparam logic [2:0] OP_RELEASE     = 3'd4;
  localparam logic [2:0] OP_PICK_FREE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN_CLR  = 3'd1,
    ST_SCAN_SOFT = 3'd2,
    ST_SCAN_PICK = 3'd3,
    ST_SCAN_MAX  = 3'd4
  } state_e;

  // A soft claim only takes a free slot; a hard claim is never downgraded.
  function automatic entry_t soft_claim(entry_t e);
    return (e == ENT_FREE) ? ENT_SOFT : e;
  endfunction

endpackage

// File: rtl/mod_148_txop_table_ram.sv
// TXOP claim table storage: NODES x 2-bit flops, async clear.
// One write port, two combinational read ports (query, scan).
module mod_148_txop_table_ram
  import mod_148_txop_pkg::*;
#(
  parameter int NODES = 256,
  parameter int ID_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [ID_W-1:0] waddr,
  input  entry_t          wdata,
  input  logic [ID_W-1:0] qaddr,
  output entry_t          qdata,
  input  logic [ID_W-1:0] saddr,
  output entry_t          sdata
);

  entry_t mem [NODES];

  // Table storage; reset returns every node to FREE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NODES; i++) begin
        mem[i] <= ENT_FREE;
      end
    end else if (we && (32'(waddr) < NODES)) begin
      mem[waddr] <= wdata;
    end
  end

  assign qdata = (32'(qaddr) < NODES) ? mem[qaddr] : ENT_FREE;
  assign sdata = (32'(saddr) < NODES) ? mem[saddr] : ENT_FREE;

endmodule

// File: rtl/mod_148_txop_table_ctrl.sv
// TXOP claim table controller: command sequencing, scans,
// max-HARD tracking and free-slot picking.
module mod_148_txop_table_ctrl
  import mod_148_txop_pkg::*;
#(
  parameter int NODES = 256,
  parameter int ID_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [ID_W-1:0] cmd_id,
  input  logic [ID_W-1:0] q_id,
  output logic            q_hard,
  output logic            q_soft,
  output logic [ID_W-1:0] max_hard_id,
  output logic            max_hard_valid,
  output logic            clear_done,
  output logic            pick_done,
  output logic [ID_W-1:0] pick_id,
  output logic            pick_found
);

  localparam logic [ID_W:0] LAST = (ID_W+1)'(NODES - 1);

  state_e          state, state_n;
  logic [ID_W:0]   idx, idx_n;
  logic [ID_W-1:0] max_id_n;
  logic            max_v_n;
  logic            clr_n, pdone_n;
  logic [ID_W-1:0] pick_id_n;
  logic            found_n;

  logic            we;
  logic [ID_W-1:0] waddr;
  entry_t          wdata;
  logic [ID_W-1:0] saddr;
  entry_t          sdata;
  entry_t          qdata;
  logic            id_ok;
  logic            at_last;

  mod_148_txop_table_ram #(
    .NODES(NODES),
    .ID_W (ID_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .qaddr(q_id),
    .qdata(qdata),
    .saddr(saddr),
    .sdata(sdata)
  );

  assign q_hard    = (qdata == ENT_HARD);
  assign q_soft    = (qdata == ENT_SOFT);
  assign cmd_ready = (state == ST_IDLE);
  assign id_ok     = (32'(cmd_id) < NODES);
  assign at_last   = (idx == LAST);

  // State, scan index and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      max_hard_id    <= '0;
      max_hard_valid <= 1'b0;
      clear_done     <= 1'b0;
      pick_done      <= 1'b0;
      pick_id        <= '0;
      pick_found     <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      max_hard_id    <= max_id_n;
      max_hard_valid <= max_v_n;
      clear_done     <= clr_n;
      pick_done      <= pdone_n;
      pick_id        <= pick_id_n;
      pick_found     <= found_n;
    end
  end

  // Command decode, scan sequencing and table write control.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    max_id_n  = max_hard_id;
    max_v_n   = max_hard_valid;
    clr_n     = 1'b0;
    pdone_n   = 1'b0;
    pick_id_n = pick_id;
    found_n   = pick_found;
    we        = 1'b0;
    waddr     = idx[ID_W-1:0];
    wdata     = ENT_FREE;
    saddr     = idx[ID_W-1:0];

    unique case (state)
      ST_IDLE: begin
        waddr = cmd_id;
        saddr = cmd_id;
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR_TABLE: begin
              state_n  = ST_SCAN_CLR;
              idx_n    = '0;
              max_v_n  = 1'b0;
              max_id_n = '0;
            end
            OP_CLEAR_SOFT: begin
              state_n = ST_SCAN_SOFT;
              idx_n   = '0;
            end
            OP_SET_SOFT: begin
              if (id_ok) begin
                we    = 1'b1;
                wdata = soft_claim(sdata);
              end
            end
            OP_SET_HARD: begin
              if (id_ok) begin
                we    = 1'b1;
                wdata = ENT_HARD;
                if (!max_hard_valid || (cmd_id > max_hard_id)) begin
                  max_id_n = cmd_id;
                  max_v_n  = 1'b1;
                end
              end
            end
            OP_RELEASE: begin
              if (id_ok) begin
                we    = 1'b1;
                wdata = ENT_FREE;
                // Losing the current maximum forces a downward rescan.
                if ((sdata == ENT_HARD) && (cmd_id == max_hard_id)) begin
                  state_n = ST_SCAN_MAX;
                  idx_n   = LAST;
                end
              end
            end
            OP_PICK_FREE: begin
              state_n = ST_SCAN_PICK;
              idx_n   = (ID_W+1)'(1);
            end
            default: ;
          endcase
        end
      end

      ST_SCAN_CLR: begin
        we    = 1'b1;
        wdata = ENT_FREE;
        if (at_last) begin
          state_n = ST_IDLE;
          clr_n   = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end

      ST_SCAN_SOFT: begin
        we    = (sdata == ENT_SOFT);
        wdata = ENT_FREE;
        if (at_last) begin
          state_n = ST_IDLE;
          clr_n   = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end

      ST_SCAN_PICK: begin
        if (sdata == ENT_FREE) begin
          state_n   = ST_IDLE;
          pdone_n   = 1'b1;
          found_n   = 1'b1;
          pick_id_n = idx[ID_W-1:0];
        end else if (at_last) begin
          state_n   = ST_IDLE;
          pdone_n   = 1'b1;
          found_n   = 1'b0;
          pick_id_n = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end

      ST_SCAN_MAX: begin
        if (sdata == ENT_HARD) begin
          state_n  = ST_IDLE;
          max_id_n = idx[ID_W-1:0];
          max_v_n  = 1'b1;
        end else if (idx == '0) begin
          state_n  = ST_IDLE;
          max_id_n = '0;
          max_v_n  = 1'b0;
        end else begin
          idx_n = idx - 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
